// File: rtl/fp_adder.sv
// fp_adder: IEEE 754 binary32 adder with round-to-nearest-even and full subnormal,
// infinity and NaN handling. The arithmetic is combinational and feeds one output register.
module fp_adder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s
);

   localparam logic [31:0] QNan = 32'h7FC0_0000;

   logic [31:0] r_s;

   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic        w_swap, w_sub;
   logic [31:0] w_l, w_sm;
   logic [7:0]  w_el, w_es, w_d;
   logic [4:0]  w_dc;
   logic [23:0] w_ml, w_ms;
   logic [49:0] w_wide;
   logic [26:0] w_lal, w_sal;
   logic [27:0] w_sum;
   logic [4:0]  w_lzc, w_shamt;
   logic [9:0]  w_lim, w_exp, w_exp_r;
   logic [26:0] w_norm;
   logic        w_rup;
   logic [24:0] w_m25;
   logic [23:0] w_mant;
   logic [31:0] w_res, w_next;

   // Operand classification
   assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign w_a_zero = (a[30:0] == 31'd0);
   assign w_b_zero = (b[30:0] == 31'd0);

   // Magnitude order of the packed encoding matches (exponent, mantissa) order
   assign w_swap = b[30:0] > a[30:0];
   assign w_l    = w_swap ? b : a;
   assign w_sm   = w_swap ? a : b;

   // Exponent field 0 behaves as exponent 1 with hidden bit 0
   assign w_el = (w_l[30:23] == 8'd0) ? 8'd1 : w_l[30:23];
   assign w_es = (w_sm[30:23] == 8'd0) ? 8'd1 : w_sm[30:23];
   assign w_ml = {|w_l[30:23], w_l[22:0]};
   assign w_ms = {|w_sm[30:23], w_sm[22:0]};

   // Alignment: [49:26] mantissa, [25] guard, [24] round, [23:0] folds into sticky.
   // A shift of 26 already leaves the whole smaller mantissa in the sticky field.
   assign w_d    = w_el - w_es;
   assign w_dc   = (w_d > 8'd26) ? 5'd26 : w_d[4:0];
   assign w_wide = {w_ms, 26'd0} >> w_dc;
   assign w_sal  = {w_wide[49:24], |w_wide[23:0]};
   assign w_lal  = {w_ml, 3'd0};

   assign w_sub = w_l[31] ^ w_sm[31];
   assign w_sum = w_sub ? ({1'b0, w_lal} - {1'b0, w_sal}) : ({1'b0, w_lal} + {1'b0, w_sal});

   // Leading-zero count of the uncarried sum; the highest set bit wins
   always_comb begin
      w_lzc = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (w_sum[i]) w_lzc = 5'(26 - i);
      end
   end

   // Normalize: carry shifts right, otherwise shift left but never below exponent 1
   always_comb begin
      w_lim   = {2'b00, w_el} - 10'd1;
      w_shamt = 5'd0;
      if (w_sum[27]) begin
         w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
         w_exp  = {2'b00, w_el} + 10'd1;
      end else begin
         w_shamt = ({5'd0, w_lzc} < w_lim) ? w_lzc : w_lim[4:0];
         w_norm  = w_sum[26:0] << w_shamt;
         w_exp   = {2'b00, w_el} - {5'd0, w_shamt};
      end
   end

   // Round to nearest even and pack; a clear hidden bit means a subnormal encoding
   always_comb begin
      w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_m25 = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
      if (w_m25[24]) begin
         w_mant  = w_m25[24:1];
         w_exp_r = w_exp + 10'd1;
      end else begin
         w_mant  = w_m25[23:0];
         w_exp_r = w_exp;
      end
      if (w_exp_r >= 10'd255) begin
         w_res = {w_l[31], 8'hFF, 23'd0};
      end else begin
         w_res = {w_l[31], (w_mant[23] ? w_exp_r[7:0] : 8'd0), w_mant[22:0]};
      end
   end

   // Special operands override the arithmetic path
   always_comb begin
      if (w_a_nan || w_b_nan) begin
         w_next = QNan;
      end else if (w_a_inf && w_b_inf) begin
         w_next = (a[31] != b[31]) ? QNan : a;
      end else if (w_a_inf) begin
         w_next = a;
      end else if (w_b_inf) begin
         w_next = b;
      end else if (w_a_zero && w_b_zero) begin
         w_next = {a[31] & b[31], 31'd0};
      end else if (w_b_zero) begin
         w_next = a;
      end else if (w_a_zero) begin
         w_next = b;
      end else if (w_sum == 28'd0) begin
         w_next = 32'd0;
      end else begin
         w_next = w_res;
      end
   end

   // Output register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) r_s <= 32'd0;
      else        r_s <= w_next;
   end

   assign s = r_s;

endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder: directed vectors for fp_adder plus a back-to-back random run checked
// against an exact wide-integer reference sum.
module tb_fp_adder;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] s;

   int n_pass  = 0;
   int n_total = 0;

   fp_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .s     (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact reference: every finite binary32 is an integer multiple of 2^-149
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic [279:0] va, vb, mag, kept, rem, half, mask, one;
      logic         sgn;
      int           p, k, e, ea, eb;
      if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0))
         return 32'h7FC0_0000;
      if (x[30:23] == 8'hFF && y[30:23] == 8'hFF)
         return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
      if (x[30:23] == 8'hFF) return x;
      if (y[30:23] == 8'hFF) return y;
      if (x[30:0] == 0 && y[30:0] == 0) return {x[31] & y[31], 31'd0};
      ea = (x[30:23] == 0) ? 1 : int'(x[30:23]);
      eb = (y[30:23] == 0) ? 1 : int'(y[30:23]);
      va = {256'd0, x[30:23] != 8'd0, x[22:0]} << (ea - 1);
      vb = {256'd0, y[30:23] != 8'd0, y[22:0]} << (eb - 1);
      if (x[31] == y[31]) begin
         mag = va + vb; sgn = x[31];
      end else if (va >= vb) begin
         mag = va - vb; sgn = x[31];
      end else begin
         mag = vb - va; sgn = y[31];
      end
      if (mag == 0) return 32'h0000_0000;
      p = -1;
      for (int i = 0; i < 280; i++) if (mag[i]) p = i;
      if (p < 23) return {sgn, 8'd0, mag[22:0]};
      k    = p - 23;
      e    = k + 1;
      one  = 1;
      kept = mag >> k;
      mask = (one << k) - one;
      rem  = mag & mask;
      half = (k == 0) ? 280'd0 : (one << (k - 1));
      if (k > 0 && (rem > half || (rem == half && kept[0]))) kept = kept + 1;
      if (kept[24]) begin
         kept = kept >> 1;
         e    = e + 1;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'd0};
      return {sgn, 8'(e), kept[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: s=%h expected %h", tag, got, exp);
   endtask

   // Drive a pair, let the next edge capture it, then compare just after the edge
   task automatic vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp);
      a = x;
      b = y;
      @(posedge clk);
      #1;
      check(tag, s, exp);
   endtask

   initial begin
      logic [31:0] x, y;
      logic [31:0] held;
      rst_n = 1'b0;
      a     = 32'h3F80_0000;
      b     = 32'h3F80_0000;
      @(posedge clk);
      #1;
      check("reset", s, 32'h0000_0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", s, 32'h4000_0000);

      vec("cancel",      32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
      vec("sub_3m1",     32'h4040_0000, 32'hBF80_0000, 32'h4000_0000);
      vec("negz_negz",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      vec("posz_negz",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
      vec("x_plus_negz", 32'hC0A0_0000, 32'h8000_0000, 32'hC0A0_0000);
      vec("tie_even",    32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      vec("above_half",  32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
      vec("tie_up",      32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
      vec("inf_minf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
      vec("nan_in",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
      vec("snan_in",     32'h3F80_0000, 32'hFF80_0001, 32'h7FC0_0000);
      vec("minf_fin",    32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
      vec("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
      vec("neg_ovf",     32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000);
      vec("sub_min",     32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
      vec("sub_to_norm", 32'h0040_0000, 32'h0040_0000, 32'h0080_0000);
      vec("norm_to_sub", 32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF);
      vec("far_sticky",  32'h4B00_0000, 32'h0000_0001, 32'h4B00_0000);
      vec("carry_rnd",   32'h3FFF_FFFF, 32'h3400_0000, 32'h4000_0000);

      // Operands changing between edges must not disturb the held result
      held = s;
      a    = 32'h4120_0000;
      b    = 32'h4120_0000;
      #3;
      check("hold_between_edges", s, held);

      // Reset in mid-stream drops the in-flight sum
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midstream_reset", s, 32'h0000_0000);
      rst_n = 1'b1;

      for (int n = 0; n < 1000; n++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 3))
            0: ;
            1: y[30:23] = x[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
            2: begin
               y[30:23] = x[30:23];
               y[31]    = ~x[31];
               y[22:4]  = x[22:4];
            end
            default: begin
               x[30:23] = 8'($urandom_range(0, 2));
               y[30:23] = 8'($urandom_range(0, 2));
            end
         endcase
         vec("random", x, y, ref_add(x, y));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
